// File: rtl/timer_pkg.sv
// Shared types for the multi-channel timer: channel modes and config-field selectors.
package timer_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_TOGGLE  = 2'd1,
    MODE_PWM     = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    SEL_PERIOD = 2'd0,
    SEL_DUTY   = 2'd1,
    SEL_MODE   = 2'd2,
    SEL_RSVD   = 2'd3
  } cfg_sel_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: free-running counter, shadow/active period and duty, mode state.
module timer_channel
  import timer_pkg::*;
#(
  parameter int               CNT_W      = 32,
  parameter logic [CNT_W-1:0] RESET_TC   = '1,
  parameter logic [CNT_W-1:0] RESET_DUTY = '0,
  parameter mode_t            RESET_MODE = MODE_TOGGLE
) (
  input  logic             clk_135_MHz,
  input  logic             rst_n,
  input  logic             wr_period,
  input  logic             wr_duty,
  input  logic             wr_mode,
  input  logic [CNT_W-1:0] wr_data,
  output logic             ch_out,
  output logic             ch_tick
);

  mode_t            mode_q, mode_d;
  logic             oneshot_done_q, oneshot_done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tc_q, tc_d, duty_q, duty_d;
  logic [CNT_W-1:0] tc_sh_q, tc_sh_d, duty_sh_q, duty_sh_d;
  logic             out_d, tick_d;
  logic             running, wrap;

  always_ff @(posedge clk_135_MHz or negedge rst_n) begin
    if (!rst_n) begin
      mode_q         <= RESET_MODE;
      oneshot_done_q <= 1'b0;
      cnt_q          <= '0;
      tc_q           <= RESET_TC;
      duty_q         <= RESET_DUTY;
      tc_sh_q        <= RESET_TC;
      duty_sh_q      <= RESET_DUTY;
      ch_out         <= 1'b0;
      ch_tick        <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      oneshot_done_q <= oneshot_done_d;
      cnt_q          <= cnt_d;
      tc_q           <= tc_d;
      duty_q         <= duty_d;
      tc_sh_q        <= tc_sh_d;
      duty_sh_q      <= duty_sh_d;
      ch_out         <= out_d;
      ch_tick        <= tick_d;
    end
  end

  always_comb begin
    running        = (mode_q != MODE_OFF) && !((mode_q == MODE_ONESHOT) && oneshot_done_q);
    wrap           = running && (cnt_q == tc_q);
    mode_d         = mode_q;
    oneshot_done_d = oneshot_done_q;
    cnt_d          = cnt_q;
    tc_d           = tc_q;
    duty_d         = duty_q;
    tc_sh_d        = tc_sh_q;
    duty_sh_d      = duty_sh_q;
    out_d          = ch_out;
    tick_d         = 1'b0;

    if (wr_period) tc_sh_d = wr_data;
    if (wr_duty)   duty_sh_d = wr_data;

    // A mode write restarts the channel and overrides any wrap on the same edge.
    if (wr_mode) begin
      mode_d         = mode_t'(wr_data[MODE_W-1:0]);
      cnt_d          = '0;
      tc_d           = tc_sh_q;
      duty_d         = duty_sh_q;
      oneshot_done_d = 1'b0;
      out_d          = (mode_d == MODE_ONESHOT);
    end else if (!running) begin
      cnt_d  = '0;
      out_d  = 1'b0;
      tc_d   = tc_sh_d;
      duty_d = duty_sh_d;
    end else begin
      // Active copies only change at the wrap, using the already-updated shadow (write-through).
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        tc_d   = tc_sh_d;
        duty_d = duty_sh_d;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      case (mode_q)
        MODE_TOGGLE:  if (wrap) out_d = !ch_out;
        MODE_PWM:     out_d = (cnt_d < duty_d);
        MODE_ONESHOT: if (wrap) begin
                        out_d          = 1'b0;
                        oneshot_done_d = 1'b1;
                      end
        default:      out_d = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multi_channel_timer.sv
// N-channel timer/blinker: decodes the config write port into per-channel enables.
module multi_channel_timer
  import timer_pkg::*;
#(
  parameter int         NUM_CH         = 4,
  parameter int         CNT_W          = 32,
  parameter int         DEFAULT_PERIOD = 135_000_000,
  parameter logic [1:0] DEFAULT_MODE   = 2'd1,
  parameter int         CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_135_MHz,
  input  logic              rst_n,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [CNT_W-1:0]  cfg_data,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ch_out,
  output logic [NUM_CH-1:0] ch_tick
);

  localparam logic [CNT_W-1:0] RESET_TC   = CNT_W'(DEFAULT_PERIOD - 1);
  localparam logic [CNT_W-1:0] RESET_DUTY = CNT_W'(DEFAULT_PERIOD / 2);
  localparam logic [CH_W:0]    NUM_CH_W   = (CH_W + 1)'(NUM_CH);

  logic              wr_ok;
  logic [NUM_CH-1:0] wr_period, wr_duty, wr_mode;

  always_comb begin
    wr_ok     = ({1'b0, cfg_ch} < NUM_CH_W) && (cfg_sel != SEL_RSVD);
    wr_period = '0;
    wr_duty   = '0;
    wr_mode   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_valid && wr_ok && (cfg_ch == CH_W'(i))) begin
        wr_period[i] = (cfg_sel == SEL_PERIOD);
        wr_duty[i]   = (cfg_sel == SEL_DUTY);
        wr_mode[i]   = (cfg_sel == SEL_MODE);
      end
    end
  end

  always_ff @(posedge clk_135_MHz or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= cfg_valid && !wr_ok;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(
      .CNT_W      (CNT_W),
      .RESET_TC   (RESET_TC),
      .RESET_DUTY (RESET_DUTY),
      .RESET_MODE (mode_t'(DEFAULT_MODE))
    ) u_ch (
      .clk_135_MHz (clk_135_MHz),
      .rst_n       (rst_n),
      .wr_period   (wr_period[g]),
      .wr_duty     (wr_duty[g]),
      .wr_mode     (wr_mode[g]),
      .wr_data     (cfg_data),
      .ch_out      (ch_out[g]),
      .ch_tick     (ch_tick[g])
    );
  end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Scoreboard bench for multi_channel_timer: cycle-stamped expectations checked by a negedge monitor.
module tb_multi_channel_timer;
  import timer_pkg::*;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 32;
  localparam int CH_W   = 3;
  localparam int K_OUT  = 0;
  localparam int K_TICK = 1;
  localparam int K_ERR  = 2;

  logic              clk_135_MHz = 1'b0;
  logic              rst_n       = 1'b1;
  logic              cfg_valid   = 1'b0;
  logic [CH_W-1:0]   cfg_ch      = '0;
  logic [1:0]        cfg_sel     = '0;
  logic [CNT_W-1:0]  cfg_data    = '0;
  logic              cfg_err;
  logic [NUM_CH-1:0] ch_out, ch_tick;

  typedef struct {
    int    cyc;
    int    kind;
    int    ch;
    logic  val;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = -3;
  int   total = 0;
  int   bad   = 0;

  multi_channel_timer #(
    .NUM_CH         (NUM_CH),
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (10),
    .DEFAULT_MODE   (2'd1)
  ) dut (
    .clk_135_MHz (clk_135_MHz),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ch      (cfg_ch),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .cfg_err     (cfg_err),
    .ch_out      (ch_out),
    .ch_tick     (ch_tick)
  );

  always #5 clk_135_MHz = ~clk_135_MHz;

  // Free-running cycle stamp, independent of the DUT reset so expectations survive a mid-run reset.
  always @(posedge clk_135_MHz) cyc <= cyc + 1;

  always @(negedge clk_135_MHz) begin
    exp_t e;
    logic act;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        e = exp_q[i];
        total++;
        if (e.cyc < cyc) begin
          bad++;
          $display("[TB] FAIL %s cyc=%0d ch=%0d: never sampled (now %0d), want %b", e.name, e.cyc, e.ch, cyc, e.val);
        end else begin
          case (e.kind)
            K_OUT:   act = ch_out[e.ch];
            K_TICK:  act = ch_tick[e.ch];
            default: act = cfg_err;
          endcase
          if (act !== e.val) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d ch=%0d: got %b want %b", e.name, e.cyc, e.ch, act, e.val);
          end
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic expect_output(input int c, input int kind, input int ch, input logic v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.kind = kind;
    e.ch   = ch;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic expect_all(input int c, input int kind, input logic v, input string nm);
    for (int i = 0; i < NUM_CH; i++) expect_output(c, kind, i, v, nm);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk_135_MHz);
      #1;
    end
  endtask

  // Drives one write so it is sampled on the next edge; returns 1 time unit after that edge.
  task automatic apply_stimulus(input int ch, input int sel, input int data);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_sel   = 2'(sel);
    cfg_data  = CNT_W'(data);
    @(posedge clk_135_MHz);
    #1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    int left;
    #1 rst_n = 1'b0;

    expect_all(-2, K_OUT, 1'b0, "rst_out");
    expect_all(-1, K_TICK, 1'b0, "rst_tick");
    expect_output(-1, K_ERR, 0, 1'b0, "rst_err");
    expect_all(9,  K_TICK, 1'b0, "dflt_tick9");
    expect_all(9,  K_OUT,  1'b0, "dflt_out9");
    expect_all(10, K_TICK, 1'b1, "dflt_tick10");
    expect_all(10, K_OUT,  1'b1, "dflt_out10");
    expect_all(11, K_TICK, 1'b0, "dflt_tick11");
    expect_all(19, K_OUT,  1'b1, "dflt_out19");
    expect_all(20, K_TICK, 1'b1, "dflt_tick20");
    expect_all(20, K_OUT,  1'b0, "dflt_out20");
    expect_output(100, K_TICK, 3, 1'b1, "ch3_tick100");
    expect_output(100, K_OUT,  3, 1'b0, "ch3_out100");
    expect_output(110, K_OUT,  4, 1'b1, "ch4_out110");
    expect_output(149, K_TICK, 3, 1'b0, "ch3_tick149");
    expect_output(150, K_TICK, 4, 1'b1, "ch4_tick150");
    expect_output(150, K_OUT,  3, 1'b1, "ch3_out150");
    wait_to(0);
    rst_n = 1'b1;

    // ch0: period 10 -> 5 written mid-count, then 5 -> 7 written on a wrap edge.
    expect_output(29, K_TICK, 0, 1'b0, "p_tick29");
    expect_output(30, K_TICK, 0, 1'b1, "p_tick30");
    expect_output(30, K_OUT,  0, 1'b1, "p_out30");
    expect_output(34, K_TICK, 0, 1'b0, "p_tick34");
    expect_output(35, K_TICK, 0, 1'b1, "p_tick35");
    expect_output(35, K_OUT,  0, 1'b0, "p_out35");
    expect_output(40, K_TICK, 0, 1'b1, "p_tick40");
    expect_output(45, K_TICK, 0, 1'b1, "p_tick45");
    expect_output(50, K_TICK, 0, 1'b1, "p_tick50");
    expect_output(50, K_OUT,  0, 1'b1, "p_out50");
    expect_output(55, K_TICK, 0, 1'b0, "wt_tick55");
    expect_output(57, K_TICK, 0, 1'b1, "wt_tick57");
    expect_output(57, K_OUT,  0, 1'b0, "wt_out57");
    expect_output(64, K_TICK, 0, 1'b1, "wt_tick64");
    wait_to(25);
    apply_stimulus(0, 0, 4);
    wait_to(49);
    apply_stimulus(0, 0, 6);

    // ch1: PWM TC=3 DUTY=2, then DUTY=0, then DUTY=8 (each picked up at a wrap).
    expect_output(73, K_OUT,  1, 1'b0, "pwm_out73");
    expect_output(73, K_TICK, 1, 1'b0, "pwm_tick73");
    expect_output(74, K_OUT,  1, 1'b1, "pwm_out74");
    expect_output(75, K_OUT,  1, 1'b0, "pwm_out75");
    expect_output(76, K_OUT,  1, 1'b0, "pwm_out76");
    expect_output(77, K_OUT,  1, 1'b1, "pwm_out77");
    expect_output(77, K_TICK, 1, 1'b1, "pwm_tick77");
    expect_output(78, K_OUT,  1, 1'b1, "pwm_out78");
    expect_output(79, K_OUT,  1, 1'b0, "pwm_out79");
    expect_output(81, K_TICK, 1, 1'b1, "pwm_tick81");
    expect_output(82, K_OUT,  1, 1'b1, "duty0_shadow82");
    expect_output(85, K_TICK, 1, 1'b1, "duty0_tick85");
    expect_output(85, K_OUT,  1, 1'b0, "duty0_out85");
    expect_output(86, K_OUT,  1, 1'b0, "duty0_out86");
    expect_output(90, K_OUT,  1, 1'b0, "duty0_out90");
    expect_output(92, K_OUT,  1, 1'b0, "duty8_out92");
    expect_output(93, K_OUT,  1, 1'b1, "duty8_out93");
    expect_output(95, K_OUT,  1, 1'b1, "duty8_out95");
    expect_output(96, K_OUT,  1, 1'b1, "duty8_out96");
    expect_output(97, K_OUT,  1, 1'b1, "duty8_out97");
    wait_to(70);
    apply_stimulus(1, 0, 3);
    apply_stimulus(1, 1, 2);
    apply_stimulus(1, 2, 2);
    wait_to(81);
    apply_stimulus(1, 1, 0);
    wait_to(90);
    apply_stimulus(1, 1, 8);

    // ch2: one-shot with TC=6 gives 7 high cycles, then idles until re-armed.
    expect_output(102, K_OUT,  2, 1'b1, "os_out102");
    expect_output(102, K_ERR,  0, 1'b0, "os_err102");
    expect_output(108, K_OUT,  2, 1'b1, "os_out108");
    expect_output(108, K_TICK, 2, 1'b0, "os_tick108");
    expect_output(109, K_OUT,  2, 1'b0, "os_out109");
    expect_output(109, K_TICK, 2, 1'b1, "os_tick109");
    expect_output(110, K_TICK, 2, 1'b0, "os_tick110");
    expect_output(116, K_OUT,  2, 1'b0, "os_out116");
    expect_output(118, K_TICK, 2, 1'b0, "os_tick118");
    expect_output(121, K_OUT,  2, 1'b1, "os2_out121");
    expect_output(127, K_OUT,  2, 1'b1, "os2_out127");
    expect_output(128, K_OUT,  2, 1'b0, "os2_out128");
    expect_output(128, K_TICK, 2, 1'b1, "os2_tick128");
    expect_output(129, K_TICK, 2, 1'b0, "os2_tick129");
    wait_to(100);
    apply_stimulus(2, 0, 6);
    apply_stimulus(2, 2, 3);
    wait_to(120);
    apply_stimulus(2, 2, 3);

    // Invalid writes: out-of-range channel, reserved field (the latter on a ch0 wrap edge).
    expect_output(131, K_ERR,  0, 1'b1, "err_ch131");
    expect_output(132, K_ERR,  0, 1'b0, "err_ch132");
    expect_output(133, K_ERR,  0, 1'b0, "err_133");
    expect_output(134, K_ERR,  0, 1'b1, "err_sel134");
    expect_output(135, K_ERR,  0, 1'b0, "err_sel135");
    expect_output(134, K_TICK, 0, 1'b1, "err_ch0tick134");
    expect_output(140, K_TICK, 0, 1'b0, "err_ch0tick140");
    expect_output(141, K_TICK, 0, 1'b1, "err_ch0tick141");
    expect_output(141, K_OUT,  0, 1'b0, "err_ch0out141");
    expect_output(148, K_TICK, 0, 1'b1, "err_ch0tick148");
    expect_output(148, K_OUT,  0, 1'b1, "err_ch0out148");
    expect_output(135, K_OUT,  1, 1'b1, "err_ch1out135");
    expect_output(135, K_OUT,  2, 1'b0, "err_ch2out135");
    wait_to(130);
    apply_stimulus(5, 0, 1);
    wait_to(133);
    apply_stimulus(0, 3, 1);

    // ch1 PWM TC=9 DUTY=9, async reset at cnt=7 with a cfg_err pulse pending.
    expect_output(153, K_OUT,  1, 1'b0, "rpwm_out153");
    expect_output(153, K_TICK, 1, 1'b0, "rpwm_tick153");
    expect_output(159, K_OUT,  1, 1'b1, "rpwm_out159");
    expect_all(160, K_OUT,  1'b0, "arst_out160");
    expect_all(160, K_TICK, 1'b0, "arst_tick160");
    expect_output(160, K_ERR, 0, 1'b0, "arst_err160");
    expect_all(161, K_OUT,  1'b0, "arst_out161");
    expect_output(161, K_ERR, 0, 1'b0, "arst_err161");
    expect_all(170, K_TICK, 1'b0, "post_tick170");
    expect_all(170, K_OUT,  1'b0, "post_out170");
    expect_all(171, K_TICK, 1'b1, "post_tick171");
    expect_all(171, K_OUT,  1'b1, "post_out171");
    expect_all(181, K_TICK, 1'b1, "post_tick181");
    expect_all(181, K_OUT,  1'b0, "post_out181");
    wait_to(150);
    apply_stimulus(1, 0, 9);
    apply_stimulus(1, 1, 9);
    apply_stimulus(1, 2, 2);
    wait_to(159);
    apply_stimulus(7, 1, 0);
    #1 rst_n = 1'b0;
    wait_to(161);
    rst_n = 1'b1;

    wait_to(185);
    @(negedge clk_135_MHz);
    #1;
    left = exp_q.size();
    if (left != 0) begin
      total += left;
      bad   += left;
      $display("[TB] FAIL scoreboard_drain: got %0d unchecked entries, want 0", left);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
